// File: rtl/painel_chamadas.sv
// Elevator call panel: queues validated floor requests and replays them as paced novaEntrada strobes.
// Optional request validation is built when PAINEL_VALIDA_EN is defined.
module painel_chamadas #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARG_PULSO   = 2,
    parameter int INTERVALO    = 4,
    parameter int NUM_ANDARES  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      botao_origem,
    input  logic [3:0]                      botao_destino,
    input  logic                            botao_enviar,
    output logic [3:0]                      origem,
    output logic [3:0]                      destino,
    output logic                            novaEntrada,
    output logic [$clog2(PROFUNDIDADE):0]   pendentes,
    output logic                            cheio,
    output logic                            erro,
    output logic [1:0]                      db_estado
);

    localparam int PW   = $clog2(PROFUNDIDADE);
    localparam int MAXC = (LARG_PULSO > INTERVALO) ? LARG_PULSO : INTERVALO;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [PW:0]   CONT_UM    = (PW+1)'(1);
    localparam logic [PW:0]   CONT_CHEIO = (PW+1)'(PROFUNDIDADE);
    localparam logic [PW-1:0] PTR_UM     = PW'(1);
    localparam logic [CW-1:0] CNT_UM     = CW'(1);
    localparam logic [CW-1:0] CARGA_ENV  = CW'(LARG_PULSO - 1);
    localparam logic [CW-1:0] CARGA_ESP  = CW'(INTERVALO - 1);

    if (NUM_ANDARES < 1 || NUM_ANDARES > 16 || PROFUNDIDADE < 2 || PROFUNDIDADE > 8 ||
        LARG_PULSO < 1 || INTERVALO < 1) begin : g_param_invalido
        $error("painel_chamadas: parametro fora da faixa");
    end

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        ENVIA   = 2'd2,
        ESPERA  = 2'd3
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ant_q;
    logic [7:0]       fila_q [PROFUNDIDADE];
    logic [PW-1:0]    cab_q, cauda_q;
    logic [PW:0]      cont_q;
    logic [3:0]       origem_q, destino_q;
    logic             nova_q, erro_q;

    logic press, pop, push, valido, cheio_w;

`ifdef PAINEL_VALIDA_EN
    assign valido = (botao_origem != botao_destino) &&
                    ({1'b0, botao_origem}  < 5'(NUM_ANDARES)) &&
                    ({1'b0, botao_destino} < 5'(NUM_ANDARES));
`else
    assign valido = 1'b1;
`endif

    assign press   = botao_enviar & ~ant_q;
    // Only CARREGA pops, and it is entered solely with a non-empty queue.
    assign pop     = (estado_q == CARREGA);
    assign cheio_w = (cont_q == CONT_CHEIO);
    assign push    = press & valido & (~cheio_w | pop);

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        unique case (estado_q)
            OCIOSO: begin
                if (cont_q != '0) estado_d = CARREGA;
            end
            CARREGA: begin
                estado_d = ENVIA;
                cnt_d    = CARGA_ENV;
            end
            ENVIA: begin
                if (cnt_q == '0) begin
                    estado_d = ESPERA;
                    cnt_d    = CARGA_ESP;
                end else begin
                    cnt_d = cnt_q - CNT_UM;
                end
            end
            ESPERA: begin
                if (cnt_q == '0) estado_d = OCIOSO;
                else             cnt_d    = cnt_q - CNT_UM;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            ant_q     <= 1'b0;
            cab_q     <= '0;
            cauda_q   <= '0;
            cont_q    <= '0;
            origem_q  <= '0;
            destino_q <= '0;
            nova_q    <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            ant_q    <= botao_enviar;
            nova_q   <= (estado_d == ENVIA);
            erro_q   <= press & ~push;
            if (push) cauda_q <= cauda_q + PTR_UM;
            if (pop) begin
                origem_q  <= fila_q[cab_q][7:4];
                destino_q <= fila_q[cab_q][3:0];
                cab_q     <= cab_q + PTR_UM;
            end
            unique case ({push, pop})
                2'b10:   cont_q <= cont_q + CONT_UM;
                2'b01:   cont_q <= cont_q - CONT_UM;
                default: cont_q <= cont_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        if (reset && push) fila_q[cauda_q] <= {botao_origem, botao_destino};
    end

    assign origem      = origem_q;
    assign destino     = destino_q;
    assign novaEntrada = nova_q;
    assign pendentes   = cont_q;
    assign cheio       = cheio_w;
    assign erro        = erro_q;
    assign db_estado   = estado_q;

endmodule

// File: doc/painel_chamadas.md
# painel_chamadas

Elevator call panel: the request-issuing end of the elevator datapath's request interface. It samples the floor switches on each press of the send button and validates the request. Accepted requests are queued in a small FIFO. Requests are then replayed one at a time onto `origem`/`destino` with a paced `novaEntrada` pulse that the datapath's rising-edge detector can capture. The datapath gives no acknowledge, so this block alone guarantees spacing and data stability.

## Interface
Parameters:
- `PROFUNDIDADE`, 4: FIFO depth in requests; power of two, 2..8.
- `LARG_PULSO`, 2: cycles `novaEntrada` stays high per request, ≥1.
- `INTERVALO`, 4: minimum low cycles after each pulse, ≥1.
- `NUM_ANDARES`, 16: valid floors are 0..NUM_ANDARES-1, ≤16.

Ports:
- `clock`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low. 0 at a rising edge resets the block.
- `botao_origem`, in, 4: origin floor switches; static level.
- `botao_destino`, in, 4: destination floor switches; static level.
- `botao_enviar`, in, 1: send button; already synchronous and debounced.
- `origem`, out, 4: origin of the request being issued; registered.
- `destino`, out, 4: destination of the request being issued; registered.
- `novaEntrada`, out, 1: request strobe; registered.
- `pendentes`, out, clog2(PROFUNDIDADE)+1: number of queued requests.
- `cheio`, out, 1: `pendentes == PROFUNDIDADE`.
- `erro`, out, 1: 1-cycle pulse when a press is rejected.
- `db_estado`, out, 2: FSM state encoding, for debug.

## Operation
- Press detection: a registered copy of `botao_enviar` is kept. A press is `botao_enviar & ~anterior`. Holding the button produces exactly one press.
- On a press, the pair {`botao_origem`, `botao_destino`} is written to the FIFO tail, unless the press is rejected.
- Rejection reasons:
  - FIFO full with no pop in the same cycle.
  - Validation failure (see Configuration).
- A rejected press pulses `erro` and leaves the FIFO unchanged.
- FSM states and transitions:
  - OCIOSO=0 → CARREGA=1 when `pendentes != 0`.
  - CARREGA → ENVIA=2: pops the FIFO head into `origem`/`destino`.
  - ENVIA → ESPERA=3 after LARG_PULSO cycles. `novaEntrada` = 1 for the whole ENVIA state.
  - ESPERA → OCIOSO after INTERVALO cycles.
- `origem`/`destino` change only on the CARREGA→ENVIA edge. They hold their value otherwise, including during ESPERA and OCIOSO.
- FIFO: circular buffer with head/tail pointers that wrap modulo PROFUNDIDADE, plus an explicit count.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - A push when full is accepted only if a pop happens in the same cycle.
- A single internal down-counter times both ENVIA and ESPERA. It is reloaded on each state entry.

## Timing
- Reset values:
  - `origem` = `destino` = 0, `novaEntrada` = 0, `pendentes` = 0, `cheio` = 0, `erro` = 0.
  - `db_estado` = 0 (OCIOSO).
  - Press register = 0, FIFO pointers = 0.
- Reset asserted mid-transfer aborts it: `novaEntrada` drops at that edge and all queued requests are discarded.
- Latency when idle and empty, with the press sampled at edge k:
  - `pendentes` = 1 after edge k.
  - CARREGA after edge k+1.
  - `origem`/`destino` valid and `novaEntrada` = 1 after edge k+2.
  - `novaEntrada` high through edge k+2+LARG_PULSO.
- Issue period per request is 2 + LARG_PULSO + INTERVALO cycles: 8 with defaults.
- `origem`/`destino` are stable from 0 cycles before `novaEntrada` rises until 1 or more cycles after it falls.
- `erro` is high for the cycle after the rejected press edge.
- `pendentes` and `cheio` are registered. They reflect a push or pop one cycle after it occurs.

## Configuration
- Macro: `PAINEL_VALIDA_EN`.
- Defined: a press is rejected (`erro` pulse) when:
  - `botao_origem == botao_destino`, or
  - either value is ≥ NUM_ANDARES.
- Undefined: no validation logic is built. Only FIFO-full causes rejection, and any 4-bit pair is queued.

## Test plan
- Reset, then a single press with origem=3, destino=9 → after 2 cycles `origem`=3, `destino`=9, `novaEntrada` high for 2 cycles, `pendentes` returns to 0.
- Five presses 1 cycle apart with a held-low gap, pairs (1,2),(2,3),(3,4),(4,5),(5,6) → the first 4 are accepted, or 5 if a pop overlaps. `erro` pulses on any overflow. Pairs are issued in order, 8 cycles apart.
- Button held high for 20 cycles → exactly one request queued.
- With `PAINEL_VALIDA_EN` defined, press (7,7) and then (2,15) with NUM_ANDARES=12 → `erro` pulses twice, `pendentes` stays 0. Without the macro, both pairs are issued.
- Push on the same cycle as a pop while full → `pendentes` stays 4, `erro` = 0, and the new pair is issued last.
- Reset driven low during ENVIA → `novaEntrada` = 0 and `pendentes` = 0 at the next edge, with no further strobes.
